// File: rtl/move_input_ctrl.sv
// Button-to-move controller: arbitrates debounced presses, moves a wrapping 3x3 cursor,
// issues moves over valid/ready and enforces a post-action lockout. All outputs registered.
module move_input_ctrl #(
  parameter int LOCKOUT_CYCLES = 25000000,
  parameter int CNT_W          = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       enable,
  input  logic       new_game,
  input  logic [8:0] occupied,
  output logic [1:0] cursor_row,
  output logic [1:0] cursor_col,
  output logic [3:0] cursor_idx,
  output logic       move_valid,
  output logic [3:0] move_idx,
  input  logic       move_ready,
  output logic       reject,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, REQ, LOCKOUT} state_t;

  // With no lockout configured, every action returns straight to IDLE.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (LOCKOUT_CYCLES > 0) ? CNT_W'(LOCKOUT_CYCLES - 1) : '0;
  localparam state_t AFTER_ACT  = (LOCKOUT_CYCLES > 0) ? LOCKOUT : IDLE;
  localparam logic   AFTER_BUSY = (LOCKOUT_CYCLES > 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       row_n, col_n;
  logic             sel_press, dir_press;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] dec3(input logic [1:0] v);
    return (v == 2'd0) ? 2'd2 : v - 2'd1;
  endfunction

  function automatic logic [3:0] idx_of(input logic [1:0] r, input logic [1:0] c);
    return {2'b00, r} * 4'd3 + {2'b00, c};
  endfunction

  // Fixed priority sel > up > down > left > right; losers are discarded.
  always_comb begin
    row_n     = cursor_row;
    col_n     = cursor_col;
    sel_press = (state == IDLE) && enable && btn_sel;
    dir_press = (state == IDLE) && enable && !btn_sel &&
                (btn_up || btn_down || btn_left || btn_right);
    if (dir_press) begin
      if (btn_up)        row_n = dec3(cursor_row);
      else if (btn_down) row_n = inc3(cursor_row);
      else if (btn_left) col_n = dec3(cursor_col);
      else               col_n = inc3(cursor_col);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      state      <= IDLE;
      cursor_row <= 2'd1;
      cursor_col <= 2'd1;
      cursor_idx <= 4'd4;
      move_valid <= 1'b0;
      move_idx   <= 4'd0;
      reject     <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
    end else begin
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_press) begin
            if (occupied[cursor_idx]) begin
              reject <= 1'b1;
              state  <= AFTER_ACT;
              busy   <= AFTER_BUSY;
              cnt    <= CNT_LOAD;
            end else begin
              move_valid <= 1'b1;
              move_idx   <= cursor_idx;
              state      <= REQ;
              busy       <= 1'b1;
            end
          end else if (dir_press) begin
            cursor_row <= row_n;
            cursor_col <= col_n;
            cursor_idx <= idx_of(row_n, col_n);
            state      <= AFTER_ACT;
            busy       <= AFTER_BUSY;
            cnt        <= CNT_LOAD;
          end
        end
        REQ: begin
          if (move_ready) begin
            move_valid <= 1'b0;
            state      <= AFTER_ACT;
            busy       <= AFTER_BUSY;
            cnt        <= CNT_LOAD;
          end
        end
        LOCKOUT: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/move_input_ctrl.md
Name: move_input_ctrl

Overview:
- Sits between the five per-button debouncers and the tic-tac-toe game FSM.
- Arbitrates simultaneous press events and moves a cursor over the 3x3 board with wrap-around.
- Rejects selects on occupied cells and issues accepted moves to the game logic over a valid/ready handshake.
- Applies a post-press lockout window so a single physical press yields exactly one action.

Parameters:
- LOCKOUT_CYCLES, 25000000: cycles during which presses are ignored after an action. Value 0 means no lockout.
- CNT_W, 25: lockout counter width. Must hold LOCKOUT_CYCLES-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_up  in  1  debounced press event; any cycle high is a press
- btn_down  in  1  debounced press event
- btn_left  in  1  debounced press event
- btn_right  in  1  debounced press event
- btn_sel  in  1  debounced select press event
- enable  in  1  game active; presses ignored while low
- new_game  in  1  one-cycle pulse: recentre cursor, drop pending request
- occupied  in  9  cell occupancy, bit i = row*3+col
- cursor_row  out  2  current row, 0..2
- cursor_col  out  2  current col, 0..2
- cursor_idx  out  4  row*3+col, for display
- move_valid  out  1  move request valid
- move_idx  out  4  requested cell index
- move_ready  in  1  game FSM accepts move
- reject  out  1  one-cycle pulse: select on occupied cell
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values (priority over everything): state IDLE; cursor (1,1); cursor_idx 4; move_valid 0; move_idx 0; reject 0; busy 0; counter 0.
- new_game (when reset is low): same as reset except occupied/enable are unaffected. Any pending move_valid drops next cycle. new_game wins over a same-cycle press or handshake.
- States: IDLE, REQ, LOCKOUT.
- IDLE, press arbitration:
  - A press is accepted only when enable=1.
  - Priority: sel > up > down > left > right. Lower-priority presses in the same cycle are discarded, not queued.
- IDLE, direction press accepted at cycle N:
  - Cursor updates, visible at N+1.
  - Up: row 0 wraps to 2, otherwise row-1. Down: row 2 wraps to 0.
  - Left and right wrap columns the same way.
  - Next state LOCKOUT.
- IDLE, select press at N with occupied[cursor_idx]=1:
  - reject=1 for cycle N+1 only.
  - Cursor unchanged; next state LOCKOUT.
- IDLE, select press at N with the cell free:
  - move_valid=1 and move_idx=cursor_idx from N+1; next state REQ.
- REQ:
  - move_valid and move_idx are held stable until the cycle M where move_valid & move_ready.
  - move_valid=0 at M+1; next state LOCKOUT.
  - All presses are dropped. Cursor is frozen.
  - enable going low does not abort the request.
- LOCKOUT:
  - Counter is loaded with LOCKOUT_CYCLES-1 on entry.
  - Each cycle: if counter==0 go to IDLE, else decrement. LOCKOUT therefore lasts exactly LOCKOUT_CYCLES cycles.
  - If LOCKOUT_CYCLES=0, the action transitions straight to IDLE.
  - Presses are dropped.
- Timing: after a direction press at N, the earliest next accepted press is at N+1+LOCKOUT_CYCLES.
- move_ready while move_valid=0 has no effect.
- Out-of-range cursor values are unreachable; no 3-value encodings are ever driven.
- Combinational input-to-output paths: none. All outputs are registered.

Test Plan:
- Reset: release reset → cursor (1,1), idx 4, move_valid 0, reject 0, busy 0.
- Wrap, LOCKOUT_CYCLES=4: up press at (0,2) → row=2, col=2, idx 8 next cycle. busy high 4 cycles, then IDLE. A second up press 2 cycles after the first is ignored; one 5 cycles after is accepted, giving row=1.
- Arbitration: sel+up+left in the same cycle, cell 4 free → move_valid=1, move_idx=4, cursor unchanged; up/left are lost.
- Handshake: move_ready held 0 for 3 cycles then 1 → move_valid/move_idx stable throughout; valid drops the cycle after the handshake. Presses during REQ leave the cursor unchanged. IDLE returns LOCKOUT_CYCLES cycles later.
- Reject and enable: occupied=9'b000010000 with a select at idx 4 → reject high exactly 1 cycle, no move_valid. With enable=0, any press leaves the state IDLE and the cursor unchanged.
- Abort and reset: new_game during REQ → move_valid 0 and cursor (1,1) next cycle, state IDLE. Reset asserted mid-LOCKOUT → IDLE, busy 0 next cycle.
